// File: rtl/morse_message_sequencer_pkg.sv
// Shared types for the Morse message sequencer: FSM encoding, FIFO entry layout
// and the character-code constants the writer side uses.
package morse_message_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [5:0] code;
        logic       word_end;
        logic       msg_end;
    } char_entry_t;

    localparam logic [5:0] CODE_DIGIT_ZERO = 6'd35;

    // A message end suppresses both gaps; otherwise exactly one gap follows.
    function automatic logic [1:0] space_flags(input char_entry_t e);
        return {e.word_end & ~e.msg_end, ~e.word_end & ~e.msg_end};
    endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Character FIFO: power-of-two depth, wrapping pointers, full/empty taken from
// the registered count only.
module morse_char_fifo
    import morse_message_sequencer_pkg::*;
#(
    parameter int P_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  char_entry_t              push_data_i,
    input  logic                     pop_i,
    output char_entry_t              head_o,
    output logic [$clog2(P_DEPTH):0] count_o,
    output logic                     ready_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(P_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(P_DEPTH);

    char_entry_t   r_mem [P_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign ready_o = (r_count < DEPTH_L);
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ready_o;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count define which words are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/morse_message_sequencer.sv
// Feeds queued characters to a Morse generator one at a time: load, start pulse,
// wait for busy to rise (with timeout) and fall, then move on.
module morse_message_sequencer
    import morse_message_sequencer_pkg::*;
#(
    parameter int P_DEPTH        = 8,
    parameter int P_BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid_i,
    input  logic [5:0]               wr_code_i,
    input  logic                     wr_word_end_i,
    input  logic                     wr_msg_end_i,
    output logic                     wr_ready_o,
    output logic [5:0]               letter_code_o,
    output logic                     letter_space_o,
    output logic                     word_space_o,
    output logic                     start_o,
    input  logic                     gen_busy_i,
    output logic [$clog2(P_DEPTH):0] fifo_count_o,
    output logic                     msg_done_o,
    output logic                     timeout_err_o
);

    localparam int TW = $clog2(P_BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_L = TW'(P_BUSY_TIMEOUT);

    state_t      r_state;
    state_t      w_next_state;
    logic [TW-1:0] r_timer;
    logic [5:0]  r_letter_code;
    logic        r_letter_space;
    logic        r_word_space;
    logic        r_msg_end;
    logic        w_pop;
    logic        w_empty;
    char_entry_t w_head;
    char_entry_t w_wr_entry;
    logic [1:0]  w_head_spaces;

    assign w_wr_entry    = '{code: wr_code_i, word_end: wr_word_end_i, msg_end: wr_msg_end_i};
    assign w_head_spaces = space_flags(w_head);

    morse_char_fifo #(.P_DEPTH(P_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (wr_valid_i),
        .push_data_i (w_wr_entry),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (fifo_count_o),
        .ready_o     (wr_ready_o),
        .empty_o     (w_empty)
    );

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        start_o       = 1'b0;
        msg_done_o    = 1'b0;
        timeout_err_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !gen_busy_i) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: w_next_state = ST_START;
            ST_START: begin
                start_o      = 1'b1;
                w_next_state = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (gen_busy_i) begin
                    w_next_state = ST_WAIT_DONE;
                end else if (r_timer == TIMEOUT_L) begin
                    timeout_err_o = 1'b1;
                    w_next_state  = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!gen_busy_i) begin
                    msg_done_o   = r_msg_end;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_timer        <= '0;
            r_letter_code  <= '0;
            r_letter_space <= 1'b0;
            r_word_space   <= 1'b0;
            r_msg_end      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_timer <= (r_state == ST_WAIT_BUSY) ? r_timer + TW'(1) : '0;
            // The hold register only changes on a pop, keeping generator inputs steady.
            if (w_pop) begin
                r_letter_code  <= w_head.code;
                r_word_space   <= w_head_spaces[1];
                r_letter_space <= w_head_spaces[0];
                r_msg_end      <= w_head.msg_end;
            end
        end
    end

    assign letter_code_o  = r_letter_code;
    assign letter_space_o = r_letter_space;
    assign word_space_o   = r_word_space;

endmodule

// File: tb/tb_morse_message_sequencer.sv
// Scoreboard bench: pushes record expected generator loads, and every start_o
// pulse pops and compares them; a small generator model answers start_o.
module tb_morse_message_sequencer;
    import morse_message_sequencer_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TMO     = 4;
    localparam int GEN_LEN = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid_i = 1'b0;
    logic [5:0] wr_code_i = '0;
    logic       wr_word_end_i = 1'b0;
    logic       wr_msg_end_i = 1'b0;
    logic       wr_ready_o;
    logic [5:0] letter_code_o;
    logic       letter_space_o;
    logic       word_space_o;
    logic       start_o;
    logic       gen_busy_i;
    logic [$clog2(DEPTH):0] fifo_count_o;
    logic       msg_done_o;
    logic       timeout_err_o;

    always #5 clk = ~clk;

    morse_message_sequencer #(.P_DEPTH(DEPTH), .P_BUSY_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid_i     (wr_valid_i),
        .wr_code_i      (wr_code_i),
        .wr_word_end_i  (wr_word_end_i),
        .wr_msg_end_i   (wr_msg_end_i),
        .wr_ready_o     (wr_ready_o),
        .letter_code_o  (letter_code_o),
        .letter_space_o (letter_space_o),
        .word_space_o   (word_space_o),
        .start_o        (start_o),
        .gen_busy_i     (gen_busy_i),
        .fifo_count_o   (fifo_count_o),
        .msg_done_o     (msg_done_o),
        .timeout_err_o  (timeout_err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [5:0] code;
        logic       ls;
        logic       ws;
        logic       me;
    } exp_t;
    exp_t sb_q[$];

    // Generator model: busy rises the cycle after start_o and lasts GEN_LEN cycles.
    int gen_cnt;
    bit gen_force_busy = 1'b0;
    bit gen_ignore = 1'b0;
    always @(posedge clk) begin
        if (!rst_n)                     gen_cnt <= 0;
        else if (start_o && !gen_ignore) gen_cnt <= GEN_LEN;
        else if (gen_cnt > 0)           gen_cnt <= gen_cnt - 1;
    end
    assign gen_busy_i = gen_force_busy || (gen_cnt != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   start_cnt = 0, done_cnt = 0, tmo_cnt = 0;
    int   last_start_cyc = 0, last_tmo_cyc = 0, low_run = 0;
    bit   last_me = 1'b0, prev_start = 1'b0, seen_start = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
            seen_start = 1'b0;
            low_run    = 0;
            last_me    = 1'b0;
        end else begin
            if (start_o) begin
                check("start_width", prev_start, 0);
                if (seen_start) check("start_gap", low_run >= 3, 1);
                start_cnt++;
                last_start_cyc = cyc;
                seen_start     = 1'b1;
                low_run        = 0;
                if (sb_q.size() == 0) begin
                    check("start_unexpected", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("letter_code", letter_code_o, mon_e.code);
                    check("letter_space", letter_space_o, mon_e.ls);
                    check("word_space", word_space_o, mon_e.ws);
                    last_me = mon_e.me;
                end
            end else begin
                low_run++;
            end
            prev_start = start_o;
            if (timeout_err_o) begin
                tmo_cnt++;
                last_tmo_cyc = cyc;
                last_me      = 1'b0;
            end
            if (msg_done_o) begin
                done_cnt++;
                check("msg_done_src", last_me, 1);
                last_me = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [5:0] code, input logic we, input logic me, output bit acc);
        wr_valid_i    = 1'b1;
        wr_code_i     = code;
        wr_word_end_i = we;
        wr_msg_end_i  = me;
        @(negedge clk);
        acc = wr_ready_o;
        if (acc) sb_q.push_back('{code, ~we & ~me, we & ~me, me});
        @(posedge clk);
        #1;
        wr_valid_i = 1'b0;
    endtask

    task automatic push_retry(input logic [5:0] code, input logic we, input logic me);
        bit acc;
        int tries = 0;
        do begin
            push(code, we, me, acc);
            tries++;
        end while (!acc && tries < 200);
        if (!acc) check("push_retry_timeout", 0, 1);
    endtask

    task automatic drain(input string tag);
        int quiet = 0;
        int budget = 0;
        while (quiet < 8 && budget < 1000) begin
            tick(1);
            budget++;
            if (sb_q.size() == 0 && fifo_count_o == 0 && !gen_busy_i && !start_o) quiet++;
            else quiet = 0;
        end
        check({tag, "_drained"}, quiet >= 8, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_letter_code"}, letter_code_o, 0);
        check({tag, "_letter_space"}, letter_space_o, 0);
        check({tag, "_word_space"}, word_space_o, 0);
        check({tag, "_start"}, start_o, 0);
        check({tag, "_msg_done"}, msg_done_o, 0);
        check({tag, "_timeout_err"}, timeout_err_o, 0);
        check({tag, "_count"}, fifo_count_o, 0);
        check({tag, "_ready"}, wr_ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int s0, d0, t0, budget;

        tick(2);
        check_reset_values("por");
        rst_n = 1'b1;
        tick(2);

        // Letter then message-ending letter.
        s0 = start_cnt; d0 = done_cnt;
        push(6'd0, 1'b0, 1'b0, acc); check("t1_acc_a", acc, 1);
        push(6'd1, 1'b0, 1'b1, acc); check("t1_acc_b", acc, 1);
        drain("t1");
        check("t1_starts", start_cnt - s0, 2);
        check("t1_done", done_cnt - d0, 1);

        // Fill while the generator is busy; full refuses even alongside a pop.
        gen_force_busy = 1'b1;
        s0 = start_cnt;
        for (int i = 0; i < 9; i++) begin
            push(6'(10 + i), 1'b1, 1'b0, acc);
            check($sformatf("t2_acc%0d", i), acc, (i < 8) ? 1 : 0);
        end
        check("t2_ready", wr_ready_o, 0);
        check("t2_count", fifo_count_o, 8);
        gen_force_busy = 1'b0;
        push(6'd30, 1'b0, 1'b0, acc);
        check("t2_full_pop_push", acc, 0);
        check("t2_count_after_pop", fifo_count_o, 7);
        drain("t2");
        check("t2_starts", start_cnt - s0, 8);

        // Generator never answers the first start: timeout drops it, next is issued.
        gen_ignore = 1'b1;
        s0 = start_cnt; d0 = done_cnt; t0 = tmo_cnt;
        push(6'd2, 1'b0, 1'b1, acc);
        push(6'd3, 1'b1, 1'b0, acc);
        budget = 0;
        while (tmo_cnt == t0 && budget < 50) begin
            tick(1);
            budget++;
        end
        gen_ignore = 1'b0;
        check("t3_timeout_seen", tmo_cnt - t0, 1);
        check("t3_latency", last_tmo_cyc - last_start_cyc, TMO + 1);
        drain("t3");
        check("t3_starts", start_cnt - s0, 2);
        check("t3_done", done_cnt - d0, 0);
        check("t3_timeouts", tmo_cnt - t0, 1);

        // Word end together with message end: no gap, message done.
        s0 = start_cnt; d0 = done_cnt;
        push(CODE_DIGIT_ZERO, 1'b1, 1'b1, acc);
        drain("t4");
        check("t4_starts", start_cnt - s0, 1);
        check("t4_done", done_cnt - d0, 1);

        // Reset while the generator is busy with three entries still queued.
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) push(6'(20 + i), 1'b0, 1'b0, acc);
        budget = 0;
        while (start_cnt == s0 && budget < 50) begin
            tick(1);
            budget++;
        end
        gen_force_busy = 1'b1;
        tick(3);
        check("t5_busy", gen_busy_i, 1);
        check("t5_count_before", fifo_count_o, 3);
        rst_n = 1'b0;
        #1;
        check_reset_values("t5");
        sb_q.delete();
        tick(2);
        gen_force_busy = 1'b0;
        rst_n = 1'b1;
        s0 = start_cnt;
        tick(20);
        check("t5_no_start", start_cnt - s0, 0);
        check("t5_count_after", fifo_count_o, 0);

        // Simultaneous push and pop at count 4, then enough traffic to wrap pointers.
        gen_force_busy = 1'b1;
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) push(6'(i), 1'b0, 1'b0, acc);
        check("t6_count4", fifo_count_o, 4);
        gen_force_busy = 1'b0;
        push(6'd4, 1'b1, 1'b0, acc);
        check("t6_simul_acc", acc, 1);
        check("t6_simul_count", fifo_count_o, 4);
        for (int i = 5; i < 20; i++) push_retry(6'(i), (i % 3) == 0, (i % 7) == 0);
        drain("t6");
        check("t6_starts", start_cnt - s0, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
